fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller that sits directly upstream of the program-counter register. It reads the current PC, issues instruction-memory reads with a req/ack handshake, and holds the fetched word in a one-entry instruction buffer for decode. It drives the PC register's load data and load enable: PC+1 on each completed fetch, or the target on an execute-stage redirect.

## Interface
- ADDR_W, 16, PC and instruction-memory address width.
- DATA_W, 16, instruction word width.
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low.
- pc_q  in  ADDR_W  current PC from the PC register.
- pc_next  out  ADDR_W  PC load value, wired to PC register pcin.
- pc_we  out  1  PC load enable, wired to PC register pcsignal.
- imem_req  out  1  read request, held until imem_ack.
- imem_addr  out  ADDR_W  read address, stable while imem_req=1.
- imem_ack  in  1  read complete; imem_rdata valid this cycle.
- imem_rdata  in  DATA_W  instruction word.
- ir_valid  out  1  instruction buffer holds a word.
- ir_data  out  DATA_W  buffered instruction.
- ir_pc  out  ADDR_W  address the buffered instruction came from.
- ir_ready  in  1  decode consumes ir_data this cycle when ir_valid=1.
- redirect  in  1  branch/jump taken; single-cycle pulse.
- redirect_target  in  ADDR_W  new PC on redirect.
- fetch_count  out  16  count of delivered (non-squashed) instructions, wraps at 16'hFFFF→0.

## Operation
- States: FETCH, FULL, DRAIN. Reset state FETCH.
- While reset=0: imem_req=0, pc_we=0, pc_next=0, ir_valid=0, ir_data=0, ir_pc=0, fetch_count=0, drain address=0.
- FETCH: imem_req=1, imem_addr=pc_q. On imem_ack with no redirect: ir_data←imem_rdata, ir_pc←pc_q, ir_valid←1, fetch_count+1; pc_we=1, pc_next=pc_q+1 (mod 2^ADDR_W, 16'hFFFF→0); next FULL.
- FULL: imem_req=0. If ir_ready: ir_valid←0, next FETCH. Otherwise hold everything.
- DRAIN: imem_req=1, imem_addr=registered drain address; on imem_ack discard data, next FETCH. pc_we=0 unless redirect.
- Redirect (any state, highest priority): pc_we=1, pc_next=redirect_target; ir_valid←0; no buffer capture and no count increment that cycle.
  - FETCH, no ack same cycle → latch pc_q as drain address, next DRAIN.
  - FETCH with ack same cycle → data discarded, next FETCH.
  - FULL → next FETCH, buffered word dropped even if ir_ready=1 (treated as not consumed).
  - DRAIN → stay DRAIN (or FETCH if ack same cycle); drain address unchanged.
- pc_we/pc_next/imem_req/imem_addr combinational from state and inputs; ir_*, fetch_count, state, drain address registered.
- imem_ack outside imem_req=1 is ignored.

## Timing
- Fetch latency: request asserted in the cycle pc_q is valid; the instruction is visible on ir_* the cycle after imem_ack; PC advances on the same edge.
- Zero-wait memory (ack same cycle as req) with ir_ready held 1: one instruction every 2 cycles (FETCH, FULL alternate).
- Redirect: new PC visible on pc_q next cycle; first fetch of target issued that cycle unless DRAIN adds ack-wait cycles.
- Reset mid-fetch: outstanding request abandoned immediately (imem_req drops in the reset cycle); memory must tolerate this. PC register resets to 16'h0000 on the same edge; first fetch is from 0 after reset releases.

## Structure
- Shared package fetch_pkg: state enum (FETCH, FULL, DRAIN), ADDR_W/DATA_W defaults, RESET_PC=16'h0000, PC_INC=1.
- Flat module; no sub-module. The PC register remains a separate instance, connected externally.

## Test plan
- Reset release, memory acks same cycle with rdata=16'hA001, ir_ready=1 → ir_valid next cycle, ir_data=16'hA001, ir_pc=0, pc_q=1, fetch_count=1.
- ir_ready=0 for 5 cycles after fill → imem_req=0, ir_* stable, pc_we=0; raise ir_ready → FETCH at pc=1.
- Ack delayed 3 cycles → imem_addr held at pc_q, pc_we only in ack cycle.
- Redirect to 16'h0040 while request outstanding at pc=5, ack 2 cycles later → data discarded, imem_addr=5 during DRAIN, next fetch addr 16'h0040, fetch_count unchanged.
- Redirect coincident with ack, and redirect in FULL with ir_ready=1 → no capture/count, ir_valid=0, pc=target.
- pc_q=16'hFFFF fetch → pc_next=0; reset pulsed mid-DRAIN → all outputs 0, state FETCH, fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam int          ADDR_W        = 16;
  localparam int          DATA_W        = 16;
  localparam int          FETCH_COUNT_W = 16;
  localparam logic [15:0] RESET_PC      = 16'h0000;
  localparam int          PC_INC        = 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read channel: request/address out, ack/data back.
interface fetch_ctrl_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues imem reads at pc_q, buffers one instruction for
// decode and drives the external PC register (PC+1 on fetch, target on redirect).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc_q,
  output logic [ADDR_W-1:0]        pc_next,
  output logic                     pc_we,
  fetch_ctrl_if.master             imem,
  output logic                     ir_valid,
  output logic [DATA_W-1:0]        ir_data,
  output logic [ADDR_W-1:0]        ir_pc,
  input  logic                     ir_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_target,
  output logic [FETCH_COUNT_W-1:0] fetch_count
);

  fetch_state_e              state_q;
  logic [ADDR_W-1:0]         drain_addr_q;
  logic                      ir_valid_q;
  logic [DATA_W-1:0]         ir_data_q;
  logic [ADDR_W-1:0]         ir_pc_q;
  logic [FETCH_COUNT_W-1:0]  fetch_count_q;
  logic                      ack;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    pc_we          = 1'b0;
    pc_next        = '0;
    if (reset) begin
      imem.imem_req = (state_q == FETCH) || (state_q == DRAIN);
      if (state_q == DRAIN) imem.imem_addr = drain_addr_q;
      if (redirect) begin
        pc_we   = 1'b1;
        pc_next = redirect_target;
      end else if (state_q == FETCH && imem.imem_ack) begin
        pc_we   = 1'b1;
        pc_next = pc_q + ADDR_W'(PC_INC);
      end
    end
  end

  // An ack only counts while a request is actually being driven.
  assign ack = imem.imem_ack && imem.imem_req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FETCH;
      drain_addr_q  <= ADDR_W'(RESET_PC);
      ir_valid_q    <= 1'b0;
      ir_data_q     <= '0;
      ir_pc_q       <= '0;
      fetch_count_q <= '0;
    end else if (redirect) begin
      ir_valid_q <= 1'b0;
      unique case (state_q)
        FETCH: begin
          if (!ack) begin
            drain_addr_q <= pc_q;
            state_q      <= DRAIN;
          end
        end
        FULL:    state_q <= FETCH;
        DRAIN:   if (ack) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack) begin
            ir_valid_q    <= 1'b1;
            ir_data_q     <= imem.imem_rdata;
            ir_pc_q       <= pc_q;
            fetch_count_q <= fetch_count_q + 1'b1;
            state_q       <= FULL;
          end
        end
        FULL: begin
          if (ir_ready) begin
            ir_valid_q <= 1'b0;
            state_q    <= FETCH;
          end
        end
        DRAIN:   if (ack) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign ir_valid    = ir_valid_q;
  assign ir_data     = ir_data_q;
  assign ir_pc       = ir_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register and a
// hand-driven instruction memory.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic              clk;
  logic              reset;
  logic [15:0]       pc_q;
  logic [15:0]       pc_next;
  logic              pc_we;
  logic              ir_valid;
  logic [15:0]       ir_data;
  logic [15:0]       ir_pc;
  logic              ir_ready;
  logic              redirect;
  logic [15:0]       redirect_target;
  logic [15:0]       fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl_if #(.ADDR_W(16), .DATA_W(16)) imem_bus ();

  fetch_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_q            (pc_q),
    .pc_next         (pc_next),
    .pc_we           (pc_we),
    .imem            (imem_bus),
    .ir_valid        (ir_valid),
    .ir_data         (ir_data),
    .ir_pc           (ir_pc),
    .ir_ready        (ir_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External PC register: synchronous active-low reset to 0.
  always @(posedge clk) begin
    if (!reset)     pc_q <= 16'h0000;
    else if (pc_we) pc_q <= pc_next;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_post();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic ack, input logic [15:0] data);
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = data;
  endtask

  initial begin
    reset = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_target = '0;
    set_mem(1'b1, 16'hA001);

    // Reset: ack presented but ignored, all outputs zero.
    to_post();
    to_neg();
    check("rst_req",    imem_bus.imem_req, 0);
    check("rst_pc_we",  pc_we, 0);
    check("rst_pc_nxt", pc_next, 0);
    to_post();
    check("rst_ir_v",   ir_valid, 0);
    check("rst_ir_d",   ir_data, 0);
    check("rst_ir_pc",  ir_pc, 0);
    check("rst_cnt",    fetch_count, 0);
    check("rst_pc",     pc_q, 0);

    // First fetch, zero-wait ack.
    reset = 1'b1;
    to_neg();
    check("f0_req",   imem_bus.imem_req, 1);
    check("f0_addr",  imem_bus.imem_addr, 16'h0000);
    check("f0_we",    pc_we, 1);
    check("f0_next",  pc_next, 16'h0001);
    to_post();
    check("f0_ir_v",  ir_valid, 1);
    check("f0_ir_d",  ir_data, 16'hA001);
    check("f0_ir_pc", ir_pc, 16'h0000);
    check("f0_pc",    pc_q, 16'h0001);
    check("f0_cnt",   fetch_count, 1);

    // Decode stalls for 5 cycles: buffer holds, no request, no PC update.
    set_mem(1'b0, 16'h0000); ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      check("stall_req", imem_bus.imem_req, 0);
      check("stall_we",  pc_we, 0);
      to_post();
      check("stall_ir_v", ir_valid, 1);
      check("stall_ir_d", ir_data, 16'hA001);
      check("stall_pc",   pc_q, 16'h0001);
    end
    ir_ready = 1'b1;
    to_neg();
    check("consume_req", imem_bus.imem_req, 0);
    to_post();
    check("consume_ir_v", ir_valid, 0);

    // Ack delayed 3 cycles at pc=1.
    for (int i = 0; i < 3; i++) begin
      to_neg();
      check("wait_req",  imem_bus.imem_req, 1);
      check("wait_addr", imem_bus.imem_addr, 16'h0001);
      check("wait_we",   pc_we, 0);
      to_post();
    end
    set_mem(1'b1, 16'hB002);
    to_neg();
    check("dly_we",   pc_we, 1);
    check("dly_next", pc_next, 16'h0002);
    to_post();
    check("dly_ir_d",  ir_data, 16'hB002);
    check("dly_ir_pc", ir_pc, 16'h0001);
    check("dly_cnt",   fetch_count, 2);
    set_mem(1'b0, 16'h0000);
    to_post();
    check("dly_drop_v", ir_valid, 0);

    // Zero-wait stream, ir_ready=1: FETCH/FULL alternate. The ack held high
    // during FULL must be ignored.
    for (int i = 0; i < 3; i++) begin
      set_mem(1'b1, 16'hC000 + 16'(i));
      to_neg();
      check("zw_addr", imem_bus.imem_addr, 16'(2 + i));
      check("zw_we",   pc_we, 1);
      to_post();
      check("zw_ir_pc", ir_pc, 16'(2 + i));
      check("zw_ir_d",  ir_data, 16'hC000 + 16'(i));
      check("zw_cnt",   fetch_count, 16'(3 + i));
      to_neg();
      check("zw_full_req", imem_bus.imem_req, 0);
      check("zw_full_we",  pc_we, 0);
      to_post();
      check("zw_full_v", ir_valid, 0);
    end
    set_mem(1'b0, 16'h0000);

    // Redirect to 0x0040 while the read of pc=5 is outstanding.
    redirect = 1'b1; redirect_target = 16'h0040;
    to_neg();
    check("rd_addr", imem_bus.imem_addr, 16'h0005);
    check("rd_we",   pc_we, 1);
    check("rd_next", pc_next, 16'h0040);
    to_post();
    redirect = 1'b0;
    check("rd_pc",  pc_q, 16'h0040);
    check("rd_cnt", fetch_count, 5);
    to_neg();
    check("dr1_req",  imem_bus.imem_req, 1);
    check("dr1_addr", imem_bus.imem_addr, 16'h0005);
    check("dr1_we",   pc_we, 0);
    to_post();
    set_mem(1'b1, 16'hDEAD);
    to_neg();
    check("dr2_addr", imem_bus.imem_addr, 16'h0005);
    check("dr2_we",   pc_we, 0);
    to_post();
    check("dr_ir_v", ir_valid, 0);
    check("dr_cnt",  fetch_count, 5);
    set_mem(1'b0, 16'h0000);
    to_neg();
    check("dr_next_addr", imem_bus.imem_addr, 16'h0040);
    check("dr_next_req",  imem_bus.imem_req, 1);

    // Redirect coincident with ack: data dropped, no count.
    set_mem(1'b1, 16'hEEEE); redirect = 1'b1; redirect_target = 16'h0080;
    to_neg();
    check("rc_next", pc_next, 16'h0080);
    to_post();
    redirect = 1'b0;
    check("rc_ir_v", ir_valid, 0);
    check("rc_cnt",  fetch_count, 5);
    check("rc_pc",   pc_q, 16'h0080);

    // Fill at 0x80, then redirect in FULL with ir_ready=1.
    set_mem(1'b1, 16'h1234);
    to_post();
    check("fl_ir_v", ir_valid, 1);
    check("fl_cnt",  fetch_count, 6);
    set_mem(1'b0, 16'h0000); redirect = 1'b1; redirect_target = 16'hFFFF;
    to_neg();
    check("rf_req",  imem_bus.imem_req, 0);
    check("rf_we",   pc_we, 1);
    check("rf_next", pc_next, 16'hFFFF);
    to_post();
    redirect = 1'b0;
    check("rf_ir_v", ir_valid, 0);
    check("rf_cnt",  fetch_count, 6);
    check("rf_pc",   pc_q, 16'hFFFF);

    // Fetch at 0xFFFF: PC wraps to 0.
    set_mem(1'b1, 16'h5555);
    to_neg();
    check("wr_addr", imem_bus.imem_addr, 16'hFFFF);
    check("wr_next", pc_next, 16'h0000);
    to_post();
    check("wr_ir_pc", ir_pc, 16'hFFFF);
    check("wr_pc",    pc_q, 16'h0000);
    check("wr_cnt",   fetch_count, 7);
    set_mem(1'b0, 16'h0000);
    to_post();

    // Fetch at 0 to move PC to 1, then redirect into DRAIN.
    set_mem(1'b1, 16'h7777);
    to_post();
    check("p1_pc", pc_q, 16'h0001);
    set_mem(1'b0, 16'h0000);
    to_post();
    redirect = 1'b1; redirect_target = 16'h0010;
    to_post();
    redirect = 1'b0;
    to_neg();
    check("dd_addr", imem_bus.imem_addr, 16'h0001);
    check("dd_pc",   pc_q, 16'h0010);
    // Redirect while draining: PC follows target, drain address unchanged.
    redirect = 1'b1; redirect_target = 16'h0020;
    to_neg();
    check("dd_rd_we",   pc_we, 1);
    check("dd_rd_next", pc_next, 16'h0020);
    to_post();
    redirect = 1'b0;
    to_neg();
    check("dd2_req",  imem_bus.imem_req, 1);
    check("dd2_addr", imem_bus.imem_addr, 16'h0001);
    check("dd2_pc",   pc_q, 16'h0020);

    // Reset mid-DRAIN.
    reset = 1'b0;
    #1;
    check("mr_req",  imem_bus.imem_req, 0);
    check("mr_we",   pc_we, 0);
    check("mr_next", pc_next, 0);
    to_post();
    check("mr_ir_v",  ir_valid, 0);
    check("mr_ir_d",  ir_data, 0);
    check("mr_ir_pc", ir_pc, 0);
    check("mr_cnt",   fetch_count, 0);
    check("mr_pc",    pc_q, 0);
    // After release the controller is in FETCH: an ack is captured.
    reset = 1'b1; set_mem(1'b1, 16'h9999);
    to_neg();
    check("pr_addr", imem_bus.imem_addr, 16'h0000);
    check("pr_we",   pc_we, 1);
    to_post();
    check("pr_ir_v", ir_valid, 1);
    check("pr_ir_d", ir_data, 16'h9999);
    check("pr_cnt",  fetch_count, 1);
    set_mem(1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
